// File: rtl/bp_pe_minsum.sv
// Multi-lane 3-stage min-sum processing element for the BP polar decoder, valid/ready with full-pipeline stall.
// Define OFFSET_MINSUM_EN to subtract OFFSET from the S2 minimum magnitude (offset min-sum).
module bp_pe_minsum #(
    parameter int unsigned BIT_N  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned OFFSET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic [LANES*BIT_N-1:0] in_a,
    input  logic [LANES*BIT_N-1:0] in_b,
    input  logic [LANES*BIT_N-1:0] in_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*BIT_N-1:0] out_llr
);

    localparam int unsigned W = LANES * BIT_N;
    localparam logic [1:0] MODE_PRE  = 2'd1;
    localparam logic [1:0] MODE_POST = 2'd2;

    localparam logic [BIT_N-1:0] MAXV = {1'b0, {(BIT_N-1){1'b1}}};
    localparam logic [BIT_N-1:0] MINV = {1'b1, {(BIT_N-1){1'b0}}};
    localparam logic [BIT_N-1:0] NEG_MAXV = {1'b1, {(BIT_N-2){1'b0}}, 1'b1};
    localparam logic signed [BIT_N:0] SUM_MAX = {2'b00, {(BIT_N-1){1'b1}}};
    localparam logic signed [BIT_N:0] SUM_MIN = {2'b11, {(BIT_N-2){1'b0}}, 1'b1};

`ifdef OFFSET_MINSUM_EN
    localparam int unsigned OFS_EN = 1;
`else
    localparam int unsigned OFS_EN = 0;
`endif
    localparam logic [BIT_N-1:0] OFS = BIT_N'(OFFSET * OFS_EN);

    // Add at BIT_N+1 bits, then clamp symmetrically to +/-MAXV
    function automatic logic [BIT_N-1:0] sat_add(input logic [BIT_N-1:0] x, input logic [BIT_N-1:0] y);
        logic signed [BIT_N:0] s;
        s = $signed({x[BIT_N-1], x}) + $signed({y[BIT_N-1], y});
        if (s > SUM_MAX)      return MAXV;
        else if (s < SUM_MIN) return NEG_MAXV;
        else                  return s[BIT_N-1:0];
    endfunction

    function automatic logic [BIT_N-1:0] mag(input logic [BIT_N-1:0] x);
        if (!x[BIT_N-1])   return x;
        else if (x == MINV) return MAXV;
        else               return -x;
    endfunction

    logic             r_v1, r_v2, r_v3;
    logic [W-1:0]     r_a1, r_t1, r_c1;
    logic [1:0]       r_mode1, r_mode2;
    logic [LANES-1:0] r_sign2;
    logic [W-1:0]     r_min2, r_c2;

    logic             w_adv1, w_adv2, w_adv3;
    logic [W-1:0]     w_t, w_min, w_res;
    logic [LANES-1:0] w_sign;

    // Each stage moves when its successor is empty or moving
    always_comb begin
        w_adv3   = !r_v3 || out_ready;
        w_adv2   = !r_v2 || w_adv3;
        w_adv1   = !r_v1 || w_adv2;
        in_ready = w_adv1;
    end

    assign out_valid = r_v3;

    // Per-lane datapath for all three stages
    always_comb begin
        logic [BIT_N-1:0] ma, mt, mn, m;
        w_t    = '0;
        w_min  = '0;
        w_sign = '0;
        w_res  = '0;
        ma     = '0;
        mt     = '0;
        mn     = '0;
        m      = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_t[k*BIT_N +: BIT_N] = (mode == MODE_PRE) ?
                sat_add(in_b[k*BIT_N +: BIT_N], in_c[k*BIT_N +: BIT_N]) : in_b[k*BIT_N +: BIT_N];

            w_sign[k] = r_a1[k*BIT_N + BIT_N - 1] ^ r_t1[k*BIT_N + BIT_N - 1];
            ma = mag(r_a1[k*BIT_N +: BIT_N]);
            mt = mag(r_t1[k*BIT_N +: BIT_N]);
            mn = (ma < mt) ? ma : mt;
            w_min[k*BIT_N +: BIT_N] = (mn > OFS) ? (mn - OFS) : '0;

            m = r_sign2[k] ? -r_min2[k*BIT_N +: BIT_N] : r_min2[k*BIT_N +: BIT_N];
            w_res[k*BIT_N +: BIT_N] = (r_mode2 == MODE_POST) ? sat_add(m, r_c2[k*BIT_N +: BIT_N]) : m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_a1    <= '0;
            r_t1    <= '0;
            r_c1    <= '0;
            r_mode1 <= '0;
            r_sign2 <= '0;
            r_min2  <= '0;
            r_c2    <= '0;
            r_mode2 <= '0;
            out_llr <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_a1    <= in_a;
                    r_t1    <= w_t;
                    r_c1    <= in_c;
                    r_mode1 <= mode;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_sign2 <= w_sign;
                    r_min2  <= w_min;
                    r_c2    <= r_c1;
                    r_mode2 <= r_mode1;
                end
            end
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) out_llr <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_bp_pe_minsum.sv
// Self-checking bench for bp_pe_minsum: directed cases, backpressure, streaming, random flow and reset flush.
module tb_bp_pe_minsum;

    localparam int BIT_N = 8;
    localparam int LANES = 2;
    localparam int W     = BIT_N * LANES;
    localparam int MAXV  = (1 << (BIT_N - 1)) - 1;
`ifdef OFFSET_MINSUM_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [1:0]   mode;
    logic [W-1:0] in_a, in_b, in_c, out_llr;

    bp_pe_minsum #(.BIT_N(BIT_N), .LANES(LANES), .OFFSET(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_llr(out_llr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];
    int           obs_q[$];
    logic         last_acc, last_out, last_in_ready, prev_stall;
    logic [W-1:0] last_llr, prev_llr;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int lane(input logic [W-1:0] v, input int k);
        logic signed [BIT_N-1:0] x;
        x = v[k*BIT_N +: BIT_N];
        return int'(x);
    endfunction

    function automatic int clamp(input int x);
        if (x > MAXV) return MAXV;
        if (x < -MAXV) return -MAXV;
        return x;
    endfunction

    function automatic int absmag(input int x);
        int r;
        r = (x < 0) ? -x : x;
        return (r > MAXV) ? MAXV : r;
    endfunction

    // Reference: apply the min-sum rules lane by lane with integer arithmetic
    function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
        logic [W-1:0] res;
        int ai, bi, ci, t, mn, r;
        res = '0;
        for (int k = 0; k < LANES; k++) begin
            ai = lane(a, k); bi = lane(b, k); ci = lane(c, k);
            t  = (m == 2'd1) ? clamp(bi + ci) : bi;
            mn = (absmag(ai) < absmag(t)) ? absmag(ai) : absmag(t);
            mn = (mn > OFS) ? mn - OFS : 0;
            r  = ((ai < 0) != (t < 0)) ? -mn : mn;
            if (m == 2'd2) r = clamp(r + ci);
            res[k*BIT_N +: BIT_N] = BIT_N'(r);
        end
        return res;
    endfunction

    // One clock: sample at negedge, score both handshakes, return just after posedge
    task automatic tick();
        @(negedge clk);
        last_acc      = in_valid && in_ready;
        last_in_ready = in_ready;
        last_out      = out_valid && out_ready;
        last_llr      = out_llr;
        if (prev_stall) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_llr), int'(prev_llr));
        end
        prev_stall = out_valid && !out_ready;
        prev_llr   = out_llr;
        if (last_acc) exp_q.push_back(model(mode, in_a, in_b, in_c));
        if (last_out) begin
            obs_q.push_back(lane(out_llr, 0));
            if (exp_q.size() == 0) check("sb_extra_beat", int'(out_llr), -1);
            else check("sb", int'(out_llr), int'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [1:0] m,
                            input int a0, input int b0, input int c0,
                            input int a1, input int b1, input int c1,
                            input int e0, input int e1);
        int lat;
        mode      = m;
        in_a      = {BIT_N'(a1), BIT_N'(a0)};
        in_b      = {BIT_N'(b1), BIT_N'(b0)};
        in_c      = {BIT_N'(c1), BIT_N'(c0)};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check({tag, "_acc"}, int'(last_acc), 1);
        in_valid = 1'b0;
        lat = 0;
        last_out = 1'b0;
        while (!last_out && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_lane0"}, lane(last_llr, 0), e0);
        check({tag, "_lane1"}, lane(last_llr, 1), e1);
    endtask

    function automatic logic [BIT_N-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return {1'b1, {(BIT_N-1){1'b0}}};
            1:       return {1'b0, {(BIT_N-1){1'b1}}};
            2:       return '0;
            default: return BIT_N'($urandom);
        endcase
    endfunction

    task automatic randomize_inputs();
        mode = 2'($urandom_range(0, 3));
        for (int k = 0; k < LANES; k++) begin
            in_a[k*BIT_N +: BIT_N] = rnd_word();
            in_b[k*BIT_N +: BIT_N] = rnd_word();
            in_c[k*BIT_N +: BIT_N] = rnd_word();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt, v, outs, not_ready;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = '0;
        in_a = '0; in_b = '0; in_c = '0;
        prev_stall = 1'b0; prev_llr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_llr", int'(out_llr), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        directed("m0", 2'd0, 20, -7, 0, -128, -128, 0, -7 + OFS, 127 - OFS);
        directed("m1", 2'd1, -50, 100, 60, 30, -100, -100, -50 + OFS, -30 + OFS);
        directed("m3", 2'd3, -50, 100, 60, 5, 5, 99, -50 + OFS, 5 - OFS);
        directed("m2a", 2'd2, 10, -30, 120, 100, 90, 100, 110 + OFS, 127);
        directed("m2b", 2'd2, 0, -5, 0, -3, -128, -128, 0, -125 - OFS);
        directed("small", 2'd0, 1, 3, 0, -1, 0, 0, 1 - OFS, 0);

        // Backpressure: five beats against a blocked output
        obs_q.delete();
        out_ready = 1'b0; mode = 2'd0; in_c = '0;
        v = 1; acc_cnt = 0;
        repeat (8) begin
            in_valid = (v <= 5);
            in_a = {BIT_N'(v), BIT_N'(v)};
            in_b = {BIT_N'(v), BIT_N'(v)};
            tick();
            if (last_acc) begin acc_cnt++; v++; end
        end
        check("bp_accepted", acc_cnt, 3);
        check("bp_in_ready_low", int'(last_in_ready), 0);
        out_ready = 1'b1;
        outs = 0;
        repeat (5) begin
            in_valid = (v <= 5);
            in_a = {BIT_N'(v), BIT_N'(v)};
            in_b = {BIT_N'(v), BIT_N'(v)};
            tick();
            if (last_acc) v++;
            if (last_out) outs++;
        end
        in_valid = 1'b0;
        check("bp_one_per_cycle", outs, 5);
        check("bp_obs_count", obs_q.size(), 5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++)
            check("bp_order", obs_q[i], i + 1 - OFS);

        // Continuous streaming: never expect in_ready to drop
        not_ready = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (1000) begin
            randomize_inputs();
            tick();
            if (!last_in_ready) not_ready++;
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("stream_full_rate", not_ready, 0);
        check("stream_drained", exp_q.size(), 0);

        // Random valid/ready traffic
        repeat (400) begin
            randomize_inputs();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        check("random_drained", exp_q.size(), 0);

        // Reset with three beats in flight
        out_ready = 1'b0; in_valid = 1'b1; acc_cnt = 0;
        for (int i = 0; i < 10 && acc_cnt < 3; i++) begin
            randomize_inputs();
            tick();
            if (last_acc) acc_cnt++;
        end
        in_valid = 1'b0;
        check("rst_fill", acc_cnt, 3);
        rst = 1'b1;
        #1;
        check("rst_async_valid", int'(out_valid), 0);
        check("rst_async_llr", int'(out_llr), 0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_release_ready", int'(in_ready), 1);
        out_ready = 1'b1; outs = 0;
        repeat (6) begin
            tick();
            if (last_out) outs++;
        end
        check("rst_no_stale", outs, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
